our_packet_dispatch: RTL and testbench
======================================

OUR_PACKET_DISPATCH -- requirements
Module: our_packet_dispatch

Interface
REQ-001 SHALL have parameter LOCAL_MAC, default 48'h02_00_00_00_00_01, the accepted unicast destination MAC.
REQ-002 SHALL have parameter ETHERTYPE, default 16'h88B5, the accepted EtherType.
REQ-003 SHALL have parameters TYPE_ONE, default 8'h01, and TYPE_TWO, default 8'h02, the packet type codes.
REQ-004 SHALL have port clock, input, 1, the single clock; all logic on its rising edge.
REQ-005 SHALL have port reset_n, input, 1, reset that is asynchronous and active-low.
REQ-006 SHALL have port rx_data, input, 8, the received byte with FCS already stripped by the MAC.
REQ-007 SHALL have port rx_valid, input, 1, qualifying rx_data.
REQ-008 SHALL have port rx_sop, input, 1, first byte of a frame, valid only with rx_valid.
REQ-009 SHALL have port rx_eop, input, 1, last byte of a frame, valid only with rx_valid.
REQ-010 SHALL have port rx_err, input, 1, frame error flag, sampled with rx_eop.
REQ-011 SHALL have port dataout, output, 8, the forwarded payload byte.
REQ-012 SHALL have port ena_one, output, 1, asserted when dataout belongs to a type-ONE packet.
REQ-013 SHALL have port ena_two, output, 1, asserted when dataout belongs to a type-TWO packet.
REQ-014 SHALL have port pkt_err, output, 1, one-cycle pulse on abort or errored forwarded packet.
REQ-015 SHALL have port drop_cnt, output, 16, count of discarded frames, saturating at 16'hFFFF.

Function
REQ-016 SHALL use five states: IDLE, HDR, TYPE, FWD and DISCARD.
REQ-017 SHALL move from IDLE to HDR on rx_valid&rx_sop; in HDR it SHALL count bytes 0..13 and latch the destination MAC (bytes 0-5) and EtherType (bytes 12-13).
REQ-018 SHALL accept a frame only if its destination equals LOCAL_MAC or 48'hFFFF_FFFF_FFFF and its EtherType equals ETHERTYPE; otherwise it SHALL go to DISCARD after byte 13.
REQ-019 SHALL treat the first payload byte (byte 14), in state TYPE, as the type code and the first byte forwarded; TYPE_ONE or TYPE_TWO SHALL select FWD with the matching enable, and any other code SHALL go to DISCARD.
REQ-020 SHALL register the outputs with a fixed latency of 1 cycle: the byte accepted at cycle N appears on dataout with ena_one or ena_two at cycle N+1.
REQ-021 SHALL assert, in FWD, exactly one of ena_one and ena_two for every valid byte through and including the rx_eop byte; the enable SHALL then drop and the state SHALL return to IDLE.
REQ-022 SHALL treat rx_valid low for one or more cycles in TYPE or FWD as an abort, because downstream stages count cycles, not bytes.
REQ-023 On abort, SHALL drop the enable in the next cycle, pulse pkt_err, increment drop_cnt, and go to DISCARD.
REQ-024 SHALL consume bytes in DISCARD until rx_eop, then go to IDLE, with no enable asserted.
REQ-025 SHALL increment drop_cnt once for every frame that is discarded or aborted.
REQ-026 SHALL treat rx_eop before byte 14 (a runt) as a drop: drop_cnt+1, return to IDLE, no enable, no pkt_err.
REQ-027 SHALL treat rx_sop while not in IDLE as an abort of the current frame and the start of HDR for the new frame in the same cycle; a forwarded frame cut off this way SHALL also pulse pkt_err.
REQ-028 SHALL, when rx_err=1 with rx_eop in FWD, still forward the byte, and pulse pkt_err one cycle after the final enable cycle; drop_cnt SHALL stay unchanged.
REQ-029 SHALL hold dataout at its last value whenever both enables are low.
REQ-030 SHALL never assert ena_one and ena_two together.

Reset
REQ-031 SHALL, when reset_n=0, immediately force state IDLE, dataout 8'h00, ena_one 0, ena_two 0, pkt_err 0, drop_cnt 16'h0000, and clear the header counter and latches.
REQ-032 SHALL, after reset_n is asserted mid-frame, ignore the remaining bytes until the next rx_sop.

Verification
REQ-033 SHALL be checked with a contiguous frame (LOCAL_MAC, 88B5, type 01, 524-byte payload): ena_one high for exactly 524 cycles starting 1 cycle after byte 14, dataout matches the payload, drop_cnt 0.
REQ-034 SHALL be checked with a broadcast frame of type 02 followed back-to-back by a type-01 frame: ena_two, then ena_one, with no overlap and no idle-cycle loss.
REQ-035 SHALL be checked with a wrong EtherType 0800, then a wrong unicast MAC, then type code 7F: no enables, drop_cnt=3.
REQ-036 SHALL be checked with a type-01 frame whose rx_valid drops for 2 cycles at payload byte 100: ena_one falls, pkt_err pulses once, drop_cnt+1, no further enable until the next sop.
REQ-037 SHALL be checked with a runt of 10 bytes, then rx_sop at HDR byte 5, then rx_err on the eop of a good frame: drop_cnt+2, the good frame is forwarded, and pkt_err pulses after its last byte.
REQ-038 SHALL be checked with reset_n pulsed low mid-FWD: outputs clear asynchronously, and the tail bytes are ignored.

Source files
------------

// File: rtl/our_packet_dispatch.sv
// our_packet_dispatch: Ethernet-style frame filter and dispatcher.
// Checks the destination MAC and EtherType, then uses the first payload
// byte as a type code and forwards the payload one byte per cycle on
// ena_one or ena_two with one cycle of latency. Aborted, filtered and
// runt frames are counted in a saturating drop counter.
module our_packet_dispatch #(
    parameter logic [47:0] LOCAL_MAC = 48'h02_00_00_00_00_01,
    parameter logic [15:0] ETHERTYPE = 16'h88B5,
    parameter logic [7:0]  TYPE_ONE  = 8'h01,
    parameter logic [7:0]  TYPE_TWO  = 8'h02
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic [7:0]  rx_data,
    input  logic        rx_valid,
    input  logic        rx_sop,
    input  logic        rx_eop,
    input  logic        rx_err,
    output logic [7:0]  dataout,
    output logic        ena_one,
    output logic        ena_two,
    output logic        pkt_err,
    output logic [15:0] drop_cnt
);

    typedef enum logic [2:0] {IDLE, HDR, TYPE, FWD, DISCARD} state_t;

    state_t      r_state, w_state_nxt;
    logic [3:0]  r_cnt;        // index of the next header byte
    logic [47:0] r_dmac;
    logic [7:0]  r_etype_hi;
    logic        r_sel_two;    // forwarding on the type-TWO lane
    logic        r_err_pend;   // rx_err seen on the last forwarded byte
    logic [7:0]  r_dataout;
    logic        r_ena_one, r_ena_two, r_pkt_err;
    logic [15:0] r_drop_cnt;

    logic w_sop, w_accept, w_type_ok;
    logic w_fwd, w_sel_two, w_drop, w_abort, w_err_set;

    // A new frame may start in any state; sop always wins.
    assign w_sop     = rx_valid & rx_sop;
    assign w_accept  = ((r_dmac == LOCAL_MAC) || (r_dmac == 48'hFFFF_FFFF_FFFF)) &&
                       ({r_etype_hi, rx_data} == ETHERTYPE);
    assign w_type_ok = (rx_data == TYPE_ONE) || (rx_data == TYPE_TWO);

    // State register plus header counter and latches
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_state    <= IDLE;
            r_cnt      <= 4'd0;
            r_dmac     <= 48'h0;
            r_etype_hi <= 8'h00;
            r_sel_two  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            if (w_sop) begin
                r_cnt  <= 4'd1;
                r_dmac <= {r_dmac[39:0], rx_data};
            end else if (rx_valid && r_state == HDR) begin
                r_cnt <= r_cnt + 4'd1;
                if (r_cnt < 4'd6)   r_dmac     <= {r_dmac[39:0], rx_data};
                if (r_cnt == 4'd12) r_etype_hi <= rx_data;
            end
            if (rx_valid && !rx_sop && r_state == TYPE)
                r_sel_two <= (rx_data == TYPE_TWO);
        end
    end

    // Next-state decode
    always_comb begin
        w_state_nxt = r_state;
        if (w_sop) begin
            w_state_nxt = rx_eop ? IDLE : HDR;
        end else if (rx_valid) begin
            case (r_state)
                HDR: begin
                    if (rx_eop)              w_state_nxt = IDLE;
                    else if (r_cnt == 4'd13) w_state_nxt = w_accept ? TYPE : DISCARD;
                end
                TYPE:    w_state_nxt = rx_eop ? IDLE : (w_type_ok ? FWD : DISCARD);
                FWD:     if (rx_eop) w_state_nxt = IDLE;
                DISCARD: if (rx_eop) w_state_nxt = IDLE;
                default: ;
            endcase
        end else if (r_state == TYPE || r_state == FWD) begin
            // A gap inside the payload breaks the cycle-exact stream downstream.
            w_state_nxt = DISCARD;
        end
    end

    // Per-cycle output events (forward, drop, abort, deferred error)
    always_comb begin
        w_fwd     = 1'b0;
        w_sel_two = 1'b0;
        w_drop    = 1'b0;
        w_abort   = 1'b0;
        w_err_set = 1'b0;
        if (w_sop) begin
            // DISCARD frames were already counted when they were rejected.
            w_drop  = (r_state == HDR) || (r_state == TYPE) || (r_state == FWD) || rx_eop;
            w_abort = (r_state == FWD);
        end else if (rx_valid) begin
            case (r_state)
                HDR:  w_drop = rx_eop || (r_cnt == 4'd13 && !w_accept);
                TYPE: begin
                    if (w_type_ok) begin
                        w_fwd     = 1'b1;
                        w_sel_two = (rx_data == TYPE_TWO);
                        w_err_set = rx_eop & rx_err;
                    end else begin
                        w_drop = 1'b1;
                    end
                end
                FWD: begin
                    w_fwd     = 1'b1;
                    w_sel_two = r_sel_two;
                    w_err_set = rx_eop & rx_err;
                end
                default: ;
            endcase
        end else if (r_state == TYPE || r_state == FWD) begin
            w_drop  = 1'b1;
            w_abort = 1'b1;
        end
    end

    // Registered outputs; dataout only moves while a byte is forwarded
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_dataout  <= 8'h00;
            r_ena_one  <= 1'b0;
            r_ena_two  <= 1'b0;
            r_pkt_err  <= 1'b0;
            r_err_pend <= 1'b0;
            r_drop_cnt <= 16'h0000;
        end else begin
            r_ena_one  <= w_fwd & ~w_sel_two;
            r_ena_two  <= w_fwd & w_sel_two;
            if (w_fwd) r_dataout <= rx_data;
            // Errored-frame pulse lands one cycle after the final enable.
            r_err_pend <= w_err_set;
            r_pkt_err  <= w_abort | r_err_pend;
            if (w_drop && r_drop_cnt != 16'hFFFF)
                r_drop_cnt <= r_drop_cnt + 16'd1;
        end
    end

    assign dataout  = r_dataout;
    assign ena_one  = r_ena_one;
    assign ena_two  = r_ena_two;
    assign pkt_err  = r_pkt_err;
    assign drop_cnt = r_drop_cnt;

endmodule

// File: tb/tb_our_packet_dispatch.sv
// Directed bench for our_packet_dispatch: frames are built byte by byte,
// a negedge monitor records enables, forwarded bytes and pkt_err pulses.
module tb_our_packet_dispatch;

    localparam logic [47:0] LMAC  = 48'h02_00_00_00_00_01;
    localparam logic [47:0] BCAST = 48'hFFFF_FFFF_FFFF;

    logic        clock = 1'b0;
    logic        reset_n;
    logic [7:0]  rx_data;
    logic        rx_valid, rx_sop, rx_eop, rx_err;
    logic [7:0]  dataout;
    logic        ena_one, ena_two, pkt_err;
    logic [15:0] drop_cnt;

    our_packet_dispatch dut (
        .clock(clock), .reset_n(reset_n), .rx_data(rx_data), .rx_valid(rx_valid),
        .rx_sop(rx_sop), .rx_eop(rx_eop), .rx_err(rx_err), .dataout(dataout),
        .ena_one(ena_one), .ena_two(ena_two), .pkt_err(pkt_err), .drop_cnt(drop_cnt)
    );

    always #5 clock = ~clock;

    int cyc = 0;
    always @(posedge clock) cyc <= cyc + 1;

    int checks = 0, errors = 0;
    int exp_drop = 0;
    int t_b14;
    int n_one, n_two, n_perr, n_ovl, first_one, last_one, first_two, last_two, perr_cyc;
    logic [7:0] q_out[$], exp_q[$], fr[$];

    // Output monitor
    always @(negedge clock) begin
        if (ena_one && ena_two) n_ovl++;
        if (ena_one) begin
            if (first_one < 0) first_one = cyc;
            last_one = cyc; n_one++; q_out.push_back(dataout);
        end
        if (ena_two) begin
            if (first_two < 0) first_two = cyc;
            last_two = cyc; n_two++; q_out.push_back(dataout);
        end
        if (pkt_err) begin n_perr++; perr_cyc = cyc; end
    end

    task automatic clear_mon();
        @(posedge clock);
        n_one = 0; n_two = 0; n_perr = 0; n_ovl = 0;
        first_one = -1; last_one = -1; first_two = -1; last_two = -1; perr_cyc = -1;
        q_out.delete(); exp_q.delete();
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(negedge clock);
            rx_valid = 0; rx_sop = 0; rx_eop = 0; rx_err = 0; rx_data = 8'h00;
        end
    endtask

    // Builds dmac | 6 src | ethertype | type code | npay-1 pattern bytes
    task automatic build(input logic [47:0] mac, input logic [15:0] et,
                         input logic [7:0] typ, input int npay, input int seed);
        fr.delete();
        for (int i = 0; i < 6; i++) fr.push_back(mac[47-8*i -: 8]);
        for (int i = 0; i < 6; i++) fr.push_back(8'(8'hA0 + i));
        fr.push_back(et[15:8]);
        fr.push_back(et[7:0]);
        fr.push_back(typ);
        for (int i = 1; i < npay; i++) fr.push_back(8'(seed + i * 3));
    endtask

    task automatic expect_payload(input int n);
        for (int i = 0; i < n; i++) exp_q.push_back(fr[14 + i]);
    endtask

    // Sends fr[first .. stop-1]; optional gap before index gap_at
    task automatic send(input int first, input int stop, input int gap_at,
                        input int gap_len, input logic err, input logic eop);
        int last;
        last = (stop == 0) ? fr.size() : stop;
        for (int i = first; i < last; i++) begin
            if (i == gap_at) idle(gap_len);
            @(negedge clock);
            rx_data  = fr[i];
            rx_valid = 1;
            rx_sop   = (i == 0);
            rx_eop   = eop && (i == last - 1);
            rx_err   = err && eop && (i == last - 1);
            if (i == 14) t_b14 = cyc + 1;
        end
    endtask

    function automatic int q_mis();
        int m, n;
        n = (q_out.size() < exp_q.size()) ? q_out.size() : exp_q.size();
        m = (q_out.size() > exp_q.size()) ? q_out.size() - exp_q.size() : exp_q.size() - q_out.size();
        for (int i = 0; i < n; i++) if (q_out[i] !== exp_q[i]) m++;
        return m;
    endfunction

    task automatic test_reset();
        reset_n = 0; rx_valid = 0; rx_sop = 0; rx_eop = 0; rx_err = 0; rx_data = 8'h00;
        repeat (2) @(posedge clock);
        #1;
        checks++; if (dataout !== 8'h00) begin errors++; $display("FAIL reset_dataout got %h want 00", dataout); end
        checks++; if (ena_one !== 1'b0 || ena_two !== 1'b0) begin errors++; $display("FAIL reset_ena got %b%b want 00", ena_one, ena_two); end
        checks++; if (pkt_err !== 1'b0) begin errors++; $display("FAIL reset_pkt_err got %b want 0", pkt_err); end
        checks++; if (drop_cnt !== 16'h0000) begin errors++; $display("FAIL reset_drop got %0d want 0", drop_cnt); end
        @(negedge clock); reset_n = 1;
        idle(2);
    endtask

    task automatic test_contiguous();
        clear_mon();
        build(LMAC, 16'h88B5, 8'h01, 524, 5);
        expect_payload(524);
        send(0, 0, -1, 0, 0, 1);
        idle(4);
        checks++; if (n_one !== 524) begin errors++; $display("FAIL contig_len got %0d want 524", n_one); end
        checks++; if (first_one !== t_b14) begin errors++; $display("FAIL contig_latency got %0d want %0d", first_one, t_b14); end
        checks++; if (n_two !== 0) begin errors++; $display("FAIL contig_ena_two got %0d want 0", n_two); end
        checks++; if (q_mis() !== 0) begin errors++; $display("FAIL contig_data got %0d mismatches want 0", q_mis()); end
        checks++; if (drop_cnt !== 16'(exp_drop)) begin errors++; $display("FAIL contig_drop got %0d want %0d", drop_cnt, exp_drop); end
        checks++; if (dataout !== fr[fr.size()-1]) begin errors++; $display("FAIL contig_hold got %h want %h", dataout, fr[fr.size()-1]); end
        checks++; if (n_perr !== 0) begin errors++; $display("FAIL contig_perr got %0d want 0", n_perr); end
    endtask

    task automatic test_back_to_back();
        clear_mon();
        build(BCAST, 16'h88B5, 8'h02, 20, 40);
        expect_payload(20);
        send(0, 0, -1, 0, 0, 1);
        build(LMAC, 16'h88B5, 8'h01, 10, 90);
        expect_payload(10);
        send(0, 0, -1, 0, 0, 1);
        idle(4);
        checks++; if (n_two !== 20) begin errors++; $display("FAIL b2b_two got %0d want 20", n_two); end
        checks++; if (n_one !== 10) begin errors++; $display("FAIL b2b_one got %0d want 10", n_one); end
        checks++; if (n_ovl !== 0) begin errors++; $display("FAIL b2b_overlap got %0d want 0", n_ovl); end
        checks++; if (first_one !== last_two + 15) begin errors++; $display("FAIL b2b_gap got %0d want %0d", first_one, last_two + 15); end
        checks++; if (q_mis() !== 0) begin errors++; $display("FAIL b2b_data got %0d mismatches want 0", q_mis()); end
        checks++; if (drop_cnt !== 16'(exp_drop)) begin errors++; $display("FAIL b2b_drop got %0d want %0d", drop_cnt, exp_drop); end
    endtask

    task automatic test_filter();
        clear_mon();
        build(LMAC, 16'h0800, 8'h01, 6, 1);  send(0, 0, -1, 0, 0, 1); idle(2);
        build(48'h02_00_00_00_00_09, 16'h88B5, 8'h01, 6, 2); send(0, 0, -1, 0, 0, 1); idle(2);
        build(LMAC, 16'h88B5, 8'h7F, 6, 3);  send(0, 0, -1, 0, 0, 1); idle(3);
        exp_drop += 3;
        checks++; if (n_one + n_two !== 0) begin errors++; $display("FAIL filter_ena got %0d want 0", n_one + n_two); end
        checks++; if (drop_cnt !== 16'(exp_drop)) begin errors++; $display("FAIL filter_drop got %0d want %0d", drop_cnt, exp_drop); end
        checks++; if (n_perr !== 0) begin errors++; $display("FAIL filter_perr got %0d want 0", n_perr); end
    endtask

    task automatic test_abort();
        clear_mon();
        build(LMAC, 16'h88B5, 8'h01, 200, 7);
        expect_payload(100);
        send(0, 0, 14 + 100, 2, 0, 1);
        idle(3);
        exp_drop += 1;
        checks++; if (n_one !== 100) begin errors++; $display("FAIL abort_len got %0d want 100", n_one); end
        checks++; if (n_perr !== 1) begin errors++; $display("FAIL abort_perr_cnt got %0d want 1", n_perr); end
        checks++; if (perr_cyc !== last_one + 1) begin errors++; $display("FAIL abort_perr_time got %0d want %0d", perr_cyc, last_one + 1); end
        checks++; if (drop_cnt !== 16'(exp_drop)) begin errors++; $display("FAIL abort_drop got %0d want %0d", drop_cnt, exp_drop); end
        checks++; if (q_mis() !== 0) begin errors++; $display("FAIL abort_data got %0d mismatches want 0", q_mis()); end
    endtask

    task automatic test_runt_sop_err();
        clear_mon();
        build(LMAC, 16'h88B5, 8'h01, 6, 11);
        send(0, 10, -1, 0, 0, 1);               // 10-byte runt
        build(BCAST, 16'h88B5, 8'h02, 6, 12);
        send(0, 5, -1, 0, 0, 0);                // cut off by the next sop
        build(LMAC, 16'h88B5, 8'h01, 8, 13);
        expect_payload(8);
        send(0, 0, -1, 0, 1, 1);                // rx_err on eop
        idle(4);
        exp_drop += 2;
        checks++; if (drop_cnt !== 16'(exp_drop)) begin errors++; $display("FAIL runt_drop got %0d want %0d", drop_cnt, exp_drop); end
        checks++; if (n_one !== 8 || n_two !== 0) begin errors++; $display("FAIL runt_fwd got %0d/%0d want 8/0", n_one, n_two); end
        checks++; if (q_mis() !== 0) begin errors++; $display("FAIL runt_data got %0d mismatches want 0", q_mis()); end
        checks++; if (n_perr !== 1) begin errors++; $display("FAIL runt_perr_cnt got %0d want 1", n_perr); end
        checks++; if (perr_cyc !== last_one + 1) begin errors++; $display("FAIL runt_perr_time got %0d want %0d", perr_cyc, last_one + 1); end
    endtask

    task automatic test_reset_mid();
        clear_mon();
        build(LMAC, 16'h88B5, 8'h02, 50, 21);
        send(0, 35, -1, 0, 0, 0);
        @(posedge clock);
        #2 reset_n = 0;
        #1;
        exp_drop = 0;
        checks++; if (n_two !== 20) begin errors++; $display("FAIL rstmid_pre got %0d want 20", n_two); end
        checks++; if (ena_two !== 1'b0 || dataout !== 8'h00) begin errors++; $display("FAIL rstmid_async got ena %b data %h want 0 00", ena_two, dataout); end
        checks++; if (drop_cnt !== 16'h0000) begin errors++; $display("FAIL rstmid_drop got %0d want 0", drop_cnt); end
        @(negedge clock);
        rx_valid = 0; rx_sop = 0; rx_eop = 0; rx_err = 0; reset_n = 1;
        clear_mon();
        send(35, 0, -1, 0, 0, 1);               // tail without sop
        idle(3);
        checks++; if (n_one + n_two !== 0) begin errors++; $display("FAIL rstmid_tail got %0d want 0", n_one + n_two); end
        checks++; if (n_perr !== 0 || drop_cnt !== 16'h0000) begin errors++; $display("FAIL rstmid_tail_err got perr %0d drop %0d want 0 0", n_perr, drop_cnt); end
        build(LMAC, 16'h88B5, 8'h01, 6, 30);
        expect_payload(6);
        send(0, 0, -1, 0, 0, 1);
        idle(3);
        checks++; if (n_one !== 6 || q_mis() !== 0) begin errors++; $display("FAIL rstmid_recover got %0d bytes %0d mism want 6 0", n_one, q_mis()); end
    endtask

    initial begin
        test_reset();
        test_contiguous();
        test_back_to_back();
        test_filter();
        test_abort();
        test_runt_sop_err();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
